hit_scorer: RTL and testbench

Scoring stage directly downstream of the mole generator and the game FSM. It synchronises the 18 slide switches and turns every switch toggle into a whack event. Each whack is checked against the mole pattern latched at the opening of each mole-up window. The block maintains the score and combo counts that the top level drives to the HEX displays.

---
 rtl/whac_pkg.sv | 22 ++
 rtl/switch_sync_edge.sv | 33 +++
 rtl/hit_scorer.sv | 154 +++++++++++++++
 tb/tb_hit_scorer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/whac_pkg.sv
// Shared constants, FSM state type and bit-count helper for the whack-a-mole scoring path.
package whac_pkg;

  localparam int          N_HOLES   = 18;
  localparam int          CNT_W     = 5;
  localparam logic [13:0] SCORE_MAX = 14'd9999;
  localparam logic [6:0]  COMBO_MAX = 7'd99;
  localparam logic [1:0]  BONUS_MAX = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_HOLES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_HOLES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/switch_sync_edge.sv
// Two-flop switch synchroniser plus toggle detector; every edge on a switch becomes a one-cycle whack.
module switch_sync_edge #(
  parameter int N = 18
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_sw,
  output logic [N-1:0] o_whack
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sw_s;
  logic [N-1:0] r_sw_prev;
  logic [1:0]   r_prime;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta    <= '0;
      r_sw_s    <= '0;
      r_sw_prev <= '0;
      r_prime   <= '0;
    end else begin
      r_meta    <= i_sw;
      r_sw_s    <= r_meta;
      r_sw_prev <= r_sw_s;
      if (r_prime != 2'd3) r_prime <= r_prime + 2'd1;
    end
  end

  // Masked until sw_prev holds a real post-reset sample, so a switch left high never scores.
  assign o_whack = (r_prime == 2'd3) ? (r_sw_s ^ r_sw_prev) : '0;

endmodule

// File: rtl/hit_scorer.sv
// Mole-window FSM, hit/miss classification and saturating score/combo counters.
module hit_scorer #(
  parameter int N_HOLES = whac_pkg::N_HOLES,
  parameter int SCORE_W = 14,
  parameter int COMBO_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               game_active,
  input  logic               mole_up_window,
  input  logic [N_HOLES-1:0] mole_positions,
  input  logic [N_HOLES-1:0] sw,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo_count,
  output logic [N_HOLES-1:0] hit_mask,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  import whac_pkg::*;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W:0] s);
    return (s > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s[SCORE_W-1:0];
  endfunction

  function automatic logic [COMBO_W-1:0] sat_combo(input logic [COMBO_W:0] c);
    return (c > (COMBO_W+1)'(COMBO_MAX)) ? COMBO_W'(COMBO_MAX) : c[COMBO_W-1:0];
  endfunction

  function automatic logic [1:0] combo_bonus(input logic [COMBO_W-1:0] c);
    logic [COMBO_W-1:0] q;
    q = c >> 2;
    return (q > COMBO_W'(BONUS_MAX)) ? BONUS_MAX : q[1:0];
  endfunction

  state_t               r_state;
  logic [N_HOLES-1:0]   r_active;
  logic [N_HOLES-1:0]   r_hit;
  logic [SCORE_W-1:0]   r_score;
  logic [COMBO_W-1:0]   r_combo;
  logic                 r_hit_pulse;
  logic                 r_miss_pulse;

  logic [N_HOLES-1:0]   w_whack;
  logic                 w_open;
  logic                 w_close;
  logic                 w_eval;
  logic [N_HOLES-1:0]   w_amask;
  logic [N_HOLES-1:0]   w_hmask;
  logic [N_HOLES-1:0]   w_hits;
  logic [N_HOLES-1:0]   w_wrong;
  logic [CNT_W-1:0]     w_nhits;
  logic [1:0]           w_bonus;
  logic [6:0]           w_points;
  logic [SCORE_W:0]     w_score_sum;
  logic [COMBO_W:0]     w_combo_sum;

  state_t               w_state_nxt;
  logic [N_HOLES-1:0]   w_active_nxt;
  logic [N_HOLES-1:0]   w_hit_nxt;
  logic [SCORE_W-1:0]   w_score_nxt;
  logic [COMBO_W-1:0]   w_combo_nxt;
  logic                 w_hp_nxt;
  logic                 w_mp_nxt;

  switch_sync_edge #(.N(N_HOLES)) u_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_sw    (sw),
    .o_whack (w_whack)
  );

  assign w_open  = (r_state == ST_IDLE) && mole_up_window && game_active;
  assign w_close = (r_state == ST_OPEN) && !(mole_up_window && game_active);
  assign w_eval  = w_open || ((r_state == ST_OPEN) && !w_close);

  // On the opening cycle the mask being latched is already the one whacks are judged against.
  assign w_amask = w_open ? mole_positions : r_active;
  assign w_hmask = w_open ? '0 : r_hit;
  assign w_hits  = w_eval ? (w_whack & w_amask & ~w_hmask) : '0;
  assign w_wrong = w_eval ? (w_whack & ~w_amask) : '0;

  assign w_nhits     = popcount(w_hits);
  assign w_bonus     = combo_bonus(r_combo);
  assign w_points    = 7'(w_nhits) * (7'(w_bonus) + 7'd1);
  assign w_score_sum = (SCORE_W+1)'(r_score) + (SCORE_W+1)'(w_points);
  assign w_combo_sum = (COMBO_W+1)'(r_combo) + (COMBO_W+1)'(w_nhits);

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_hit_nxt    = r_hit;
    w_score_nxt  = r_score;
    w_combo_nxt  = r_combo;
    w_hp_nxt     = 1'b0;
    w_mp_nxt     = 1'b0;
    if (w_open) begin
      w_state_nxt  = ST_OPEN;
      w_active_nxt = mole_positions;
      w_hit_nxt    = '0;
    end
    if (w_close) begin
      w_state_nxt = ST_IDLE;
      if (|(r_active & ~r_hit)) begin
        w_mp_nxt    = 1'b1;
        w_combo_nxt = '0;
      end
    end
    if (|w_hits) begin
      w_score_nxt = sat_score(w_score_sum);
      w_combo_nxt = sat_combo(w_combo_sum);
      w_hit_nxt   = w_hmask | w_hits;
      w_hp_nxt    = 1'b1;
    end
    // A wrong whack breaks the streak even when it lands alongside a hit.
    if (|w_wrong) w_combo_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_active     <= '0;
      r_hit        <= '0;
      r_score      <= '0;
      r_combo      <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else if (clear) begin
      r_state      <= ST_IDLE;
      r_active     <= '0;
      r_hit        <= '0;
      r_score      <= '0;
      r_combo      <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_active     <= w_active_nxt;
      r_hit        <= w_hit_nxt;
      r_score      <= w_score_nxt;
      r_combo      <= w_combo_nxt;
      r_hit_pulse  <= w_hp_nxt;
      r_miss_pulse <= w_mp_nxt;
    end
  end

  assign score       = r_score;
  assign combo_count = r_combo;
  assign hit_mask    = r_hit;
  assign hit_pulse   = r_hit_pulse;
  assign miss_pulse  = r_miss_pulse;

endmodule

// File: tb/tb_hit_scorer.sv
// Directed bench for hit_scorer: prime, hit/wrong/miss, bonus tiers, saturation and mid-window reset.
module tb_hit_scorer;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        game_active;
  logic        mole_up_window;
  logic [17:0] mole_positions;
  logic [17:0] sw;
  logic [13:0] score;
  logic [6:0]  combo_count;
  logic [17:0] hit_mask;
  logic        hit_pulse;
  logic        miss_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int seen;

  hit_scorer dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .game_active    (game_active),
    .mole_up_window (mole_up_window),
    .mole_positions (mole_positions),
    .sw             (sw),
    .score          (score),
    .combo_count    (combo_count),
    .hit_mask       (hit_mask),
    .hit_pulse      (hit_pulse),
    .miss_pulse     (miss_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic open_win(input logic [17:0] mole);
    mole_positions = mole;
    mole_up_window = 1'b1;
    tick();
  endtask

  task automatic close_win();
    mole_up_window = 1'b0;
    tick();
  endtask

  task automatic whack(input logic [17:0] mask);
    sw = sw ^ mask;
    repeat (3) tick();
  endtask

  initial begin
    rst            = 1'b1;
    clear          = 1'b0;
    game_active    = 1'b1;
    mole_up_window = 1'b1;
    mole_positions = 18'h3FFFF;
    sw             = 18'h3FFFF;
    repeat (3) tick();
    check("rst_score", score, 0);
    check("rst_combo", combo_count, 0);
    check("rst_hit_mask", hit_mask, 0);
    check("rst_hit_pulse", hit_pulse, 0);
    check("rst_miss_pulse", miss_pulse, 0);

    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (hit_pulse) seen++;
    end
    check("prime_hit_pulses", seen, 0);
    check("prime_score", score, 0);
    check("prime_hit_mask", hit_mask, 0);

    close_win();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("clear_score", score, 0);
    check("clear_combo", combo_count, 0);

    open_win(18'h00210);
    whack(18'h00010);
    check("hit4_score", score, 1);
    check("hit4_combo", combo_count, 1);
    check("hit4_mask", hit_mask, 18'h00010);
    check("hit4_pulse", hit_pulse, 1);
    tick();
    check("hit4_pulse_one_cycle", hit_pulse, 0);
    whack(18'h00010);
    check("rewhack_score", score, 1);
    check("rewhack_combo", combo_count, 1);
    check("rewhack_pulse", hit_pulse, 0);
    whack(18'h04000);
    check("wrong_combo", combo_count, 0);
    check("wrong_score", score, 1);
    close_win();
    check("miss_pulse", miss_pulse, 1);
    tick();
    check("miss_pulse_one_cycle", miss_pulse, 0);

    open_win(18'h00210);
    whack(18'h00010);
    check("b_score", score, 2);
    check("b_combo", combo_count, 1);
    close_win();
    check("b_miss_pulse", miss_pulse, 1);
    check("b_miss_combo", combo_count, 0);
    tick();

    open_win(18'h00000);
    close_win();
    check("empty_no_miss", miss_pulse, 0);

    open_win(18'h00007);
    whack(18'h00007);
    check("c_score", score, 5);
    check("c_combo", combo_count, 3);
    check("c_mask", hit_mask, 18'h00007);
    close_win();
    check("c_no_miss", miss_pulse, 0);
    check("c_combo_kept", combo_count, 3);

    open_win(18'h00210);
    whack(18'h00210);
    check("dual_score", score, 7);
    check("dual_combo", combo_count, 5);
    close_win();

    open_win(18'h00007);
    whack(18'h00007);
    check("e_score", score, 13);
    check("e_combo", combo_count, 8);
    close_win();

    open_win(18'h00020);
    whack(18'h00020);
    check("bonus2_score", score, 16);
    check("bonus2_combo", combo_count, 9);
    close_win();

    open_win(18'h3FFFF);
    whack(18'h3FFFF);
    check("g_score", score, 70);
    check("g_combo", combo_count, 27);
    close_win();

    repeat (137) begin
      open_win(18'h3FFFF);
      whack(18'h3FFFF);
      close_win();
    end
    check("bulk_score", score, 9934);
    check("bulk_combo_sat", combo_count, 99);

    open_win(18'h0FFFF);
    whack(18'h0FFFF);
    check("score_9998", score, 9998);
    close_win();

    open_win(18'h10000);
    whack(18'h10000);
    check("score_sat", score, 9999);
    check("combo_sat_hit", combo_count, 99);
    check("sat_hit_pulse", hit_pulse, 1);
    close_win();

    open_win(18'h00210);
    whack(18'h00010);
    check("pre_rst_mask", hit_mask, 18'h00010);
    rst = 1'b1;
    #1;
    check("midrst_score", score, 0);
    check("midrst_combo", combo_count, 0);
    check("midrst_mask", hit_mask, 0);
    check("midrst_hit_pulse", hit_pulse, 0);
    check("midrst_miss_pulse", miss_pulse, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
